// File: rtl/xconv_seq.sv
// xconv_seq: ctr-bus master that steps through the output positions of a chained
// xversat convolution. For each position it writes the stage addresses, triggers RUN_DONE and polls it.
module xconv_seq #(
  parameter int DATA_W     = 32,
  parameter int CTR_ADDR_W = 10,
  parameter int NSTAGE_W   = 3,
  parameter int DIM_W      = 8,
  parameter logic [CTR_ADDR_W-1:0] IN_START_ADDR  = 10'd20,
  parameter logic [CTR_ADDR_W-1:0] OUT_START_ADDR = 10'd36,
  parameter logic [CTR_ADDR_W-1:0] RUN_DONE_ADDR  = 10'h3FF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DIM_W-1:0]      i_out_rows,
  input  logic [DIM_W-1:0]      i_out_cols,
  input  logic [DIM_W-1:0]      i_in_stride,
  input  logic [NSTAGE_W:0]     i_n_stages,
  input  logic [15:0]           i_poll_max,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_ctr_valid,
  output logic                  o_ctr_we,
  output logic [CTR_ADDR_W-1:0] o_ctr_addr,
  output logic [DATA_W-1:0]     o_ctr_data_in,
  input  logic [DATA_W-1:0]     i_ctr_data_out
);

  localparam int SH = CTR_ADDR_W - NSTAGE_W;
  localparam int IW = 2 * DIM_W;
  localparam logic [NSTAGE_W:0] ONE_ST  = {{NSTAGE_W{1'b0}}, 1'b1};
  localparam logic [DIM_W-1:0]  ONE_DIM = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]     ONE_IDX = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ONE_DAT = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_IN  = 3'd1,
    S_WR_OUT = 3'd2,
    S_WR_RUN = 3'd3,
    S_POLL   = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t                r_state, w_state;
  logic                  r_gap, w_gap;
  logic [NSTAGE_W:0]     r_stage, w_stage;
  logic [DIM_W-1:0]      r_row, w_row, r_col, w_col;
  logic [IW-1:0]         r_in_idx, w_in_idx, r_row_base, w_row_base, r_out_idx, w_out_idx;
  logic [15:0]           r_poll_cnt, w_poll_cnt;
  logic [DIM_W-1:0]      r_rows, w_rows, r_cols, w_cols, r_stride, w_stride;
  logic [NSTAGE_W:0]     r_nst, w_nst;
  logic [15:0]           r_pmax, w_pmax;
  logic                  r_busy, w_busy, r_done, w_done, r_err, w_err;
  logic                  r_valid, w_valid, r_we, w_we;
  logic [CTR_ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0]     r_data, w_data;

  function automatic logic [CTR_ADDR_W-1:0] stage_base(input logic [NSTAGE_W:0] s);
    stage_base = {s[NSTAGE_W-1:0], {SH{1'b0}}};
  endfunction

  // Next-state, counter and bus-request logic; r_gap marks the idle cycle after each access
  always_comb begin
    w_state    = r_state;
    w_gap      = r_gap;
    w_stage    = r_stage;
    w_row      = r_row;
    w_col      = r_col;
    w_in_idx   = r_in_idx;
    w_row_base = r_row_base;
    w_out_idx  = r_out_idx;
    w_poll_cnt = r_poll_cnt;
    w_rows     = r_rows;
    w_cols     = r_cols;
    w_stride   = r_stride;
    w_nst      = r_nst;
    w_pmax     = r_pmax;
    w_busy     = r_busy;
    w_err      = r_err;
    w_done     = 1'b0;
    w_valid    = 1'b0;
    w_we       = 1'b0;
    w_addr     = {CTR_ADDR_W{1'b0}};
    w_data     = {DATA_W{1'b0}};

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_rows     = i_out_rows;
          w_cols     = i_out_cols;
          w_stride   = i_in_stride;
          w_nst      = i_n_stages;
          w_pmax     = i_poll_max;
          w_err      = 1'b0;
          w_busy     = 1'b1;
          w_stage    = {(NSTAGE_W+1){1'b0}};
          w_row      = {DIM_W{1'b0}};
          w_col      = {DIM_W{1'b0}};
          w_in_idx   = {IW{1'b0}};
          w_row_base = {IW{1'b0}};
          w_out_idx  = {IW{1'b0}};
          w_poll_cnt = 16'd0;
          w_gap      = 1'b0;
          if ((i_out_rows == {DIM_W{1'b0}}) || (i_out_cols == {DIM_W{1'b0}})) begin
            w_state = S_FIN;
          end else begin
            // First access goes out straight from the start edge
            w_state = S_WR_IN;
            w_valid = 1'b1;
            w_we    = 1'b1;
            w_addr  = IN_START_ADDR;
          end
        end else begin
          w_busy = 1'b0;
        end
      end

      S_FIN: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_done  = 1'b1;
      end

      S_WR_IN, S_WR_OUT, S_WR_RUN, S_POLL: begin
        if (r_gap) begin
          w_gap   = 1'b0;
          w_valid = 1'b1;
          case (r_state)
            S_WR_IN: begin
              w_we   = 1'b1;
              w_addr = stage_base(r_stage) + IN_START_ADDR;
              w_data = DATA_W'(r_in_idx);
            end
            S_WR_OUT: begin
              w_we   = 1'b1;
              w_addr = stage_base(r_nst - ONE_ST) + OUT_START_ADDR;
              w_data = DATA_W'(r_out_idx);
            end
            S_WR_RUN: begin
              w_we   = 1'b1;
              w_addr = RUN_DONE_ADDR;
              w_data = ONE_DAT;
            end
            default: begin
              w_addr = RUN_DONE_ADDR;
            end
          endcase
        end else begin
          w_gap = 1'b1;
          case (r_state)
            S_WR_IN: begin
              if ((r_stage + ONE_ST) < r_nst) begin
                w_stage = r_stage + ONE_ST;
              end else begin
                w_state = S_WR_OUT;
              end
            end
            S_WR_OUT: w_state = S_WR_RUN;
            S_WR_RUN: begin
              w_state    = S_POLL;
              w_poll_cnt = 16'd0;
            end
            default: begin
              // Read data is valid on the edge that closes the poll access
              if (i_ctr_data_out != {DATA_W{1'b0}}) begin
                w_stage    = {(NSTAGE_W+1){1'b0}};
                w_poll_cnt = 16'd0;
                w_out_idx  = r_out_idx + ONE_IDX;
                if ((r_col + ONE_DIM) < r_cols) begin
                  w_col    = r_col + ONE_DIM;
                  w_in_idx = r_in_idx + ONE_IDX;
                  w_state  = S_WR_IN;
                end else begin
                  w_col      = {DIM_W{1'b0}};
                  w_row      = r_row + ONE_DIM;
                  w_row_base = r_row_base + IW'(r_stride);
                  w_in_idx   = r_row_base + IW'(r_stride);
                  if ((r_row + ONE_DIM) == r_rows) begin
                    w_state = S_FIN;
                  end else begin
                    w_state = S_WR_IN;
                  end
                end
              end else if ((r_pmax != 16'd0) && ((r_poll_cnt + 16'd1) == r_pmax)) begin
                w_err   = 1'b1;
                w_state = S_FIN;
              end else begin
                w_poll_cnt = r_poll_cnt + 16'd1;
              end
            end
          endcase
        end
      end

      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State, counter, configuration and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_gap      <= 1'b0;
      r_stage    <= {(NSTAGE_W+1){1'b0}};
      r_row      <= {DIM_W{1'b0}};
      r_col      <= {DIM_W{1'b0}};
      r_in_idx   <= {IW{1'b0}};
      r_row_base <= {IW{1'b0}};
      r_out_idx  <= {IW{1'b0}};
      r_poll_cnt <= 16'd0;
      r_rows     <= {DIM_W{1'b0}};
      r_cols     <= {DIM_W{1'b0}};
      r_stride   <= {DIM_W{1'b0}};
      r_nst      <= {(NSTAGE_W+1){1'b0}};
      r_pmax     <= 16'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= {CTR_ADDR_W{1'b0}};
      r_data     <= {DATA_W{1'b0}};
    end else begin
      r_state    <= w_state;
      r_gap      <= w_gap;
      r_stage    <= w_stage;
      r_row      <= w_row;
      r_col      <= w_col;
      r_in_idx   <= w_in_idx;
      r_row_base <= w_row_base;
      r_out_idx  <= w_out_idx;
      r_poll_cnt <= w_poll_cnt;
      r_rows     <= w_rows;
      r_cols     <= w_cols;
      r_stride   <= w_stride;
      r_nst      <= w_nst;
      r_pmax     <= w_pmax;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
      r_valid    <= w_valid;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_data     <= w_data;
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_ctr_valid   = r_valid;
  assign o_ctr_we      = r_we;
  assign o_ctr_addr    = r_addr;
  assign o_ctr_data_in = r_data;

endmodule

// File: tb/tb_xconv_seq.sv
// Bench for xconv_seq: a table of loop configurations, each expanded into an expected
// bus-access queue that a negedge monitor checks, plus reset/start-masking sequences.
module tb_xconv_seq;

  localparam int IN_A  = 20;
  localparam int OUT_A = 36;
  localparam int RUN_A = 1023;
  localparam int STEP  = 128;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  out_rows, out_cols, in_stride;
  logic [3:0]  n_stages;
  logic [15:0] poll_max;
  logic        busy, done, err, ctr_valid, ctr_we;
  logic [9:0]  ctr_addr;
  logic [31:0] ctr_data_in, ctr_data_out;

  xconv_seq #(
    .DATA_W(32), .CTR_ADDR_W(10), .NSTAGE_W(3), .DIM_W(8),
    .IN_START_ADDR(10'd20), .OUT_START_ADDR(10'd36), .RUN_DONE_ADDR(10'h3FF)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_out_rows(out_rows), .i_out_cols(out_cols), .i_in_stride(in_stride),
    .i_n_stages(n_stages), .i_poll_max(poll_max),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_ctr_valid(ctr_valid), .o_ctr_we(ctr_we), .o_ctr_addr(ctr_addr),
    .o_ctr_data_in(ctr_data_in), .i_ctr_data_out(ctr_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int we;
    int addr;
    int data;
  } acc_t;

  typedef struct {
    int rows, cols, stride, nst, pmax, zeros0, always0, mask, exp_busy, exp_err;
  } vec_t;

  acc_t exp_q[$];
  int   resp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_acc = 0;

  function automatic void chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Scoreboard: every access is compared against the head of the expected queue
  always @(negedge clk) begin
    acc_t e;
    if (ctr_valid) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL access_extra: got we=%0b addr=%0d data=%0d, expected no access",
                 ctr_we, ctr_addr, ctr_data_in);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ((int'(ctr_we) != e.we) || (int'(ctr_addr) != e.addr) ||
            ((e.we == 1) && (int'(ctr_data_in) != e.data))) begin
          failures++;
          $display("FAIL access#%0d: got we=%0b addr=%0d data=%0d, expected we=%0d addr=%0d data=%0d",
                   n_acc, ctr_we, ctr_addr, ctr_data_in, e.we, e.addr, e.data);
        end
      end
      if (!ctr_we && resp_q.size() > 0) ctr_data_out = 32'(resp_q.pop_front());
      else ctr_data_out = 32'd0;
    end else begin
      ctr_data_out = 32'd0;
    end
  end

  task automatic push(input int we, input int addr, input int data);
    acc_t a;
    a.we = we; a.addr = addr; a.data = data;
    exp_q.push_back(a);
  endtask

  task automatic build(input vec_t v);
    bit stop;
    exp_q.delete();
    resp_q.delete();
    stop = 1'b0;
    if (v.rows == 0 || v.cols == 0) return;
    for (int r = 0; r < v.rows && !stop; r++) begin
      for (int c = 0; c < v.cols && !stop; c++) begin
        int p;
        int z;
        p = r * v.cols + c;
        for (int s = 0; s < v.nst; s++) push(1, s * STEP + IN_A, r * v.stride + c);
        push(1, (v.nst - 1) * STEP + OUT_A, p);
        push(1, RUN_A, 1);
        if (v.always0 != 0) begin
          for (int k = 0; k < v.pmax; k++) begin
            push(0, RUN_A, 0);
            resp_q.push_back(0);
          end
          stop = 1'b1;
        end else begin
          z = (p == 0) ? v.zeros0 : 0;
          for (int k = 0; k < z; k++) begin
            push(0, RUN_A, 0);
            resp_q.push_back(0);
          end
          push(0, RUN_A, 0);
          resp_q.push_back(1);
        end
      end
    end
  endtask

  task automatic apply(input vec_t v);
    out_rows  = 8'(v.rows);
    out_cols  = 8'(v.cols);
    in_stride = 8'(v.stride);
    n_stages  = 4'(v.nst);
    poll_max  = 16'(v.pmax);
  endtask

  task automatic garble();
    out_rows = 8'd1; out_cols = 8'd1; in_stride = 8'd0; n_stages = 4'd1; poll_max = 16'd1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int cyc, busy_cnt, done_cyc;
    build(v);
    @(negedge clk);
    apply(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    garble();
    cyc = 1; busy_cnt = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < 3000) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        chk(busy == 1'b0, $sformatf("v%0d busy_at_done", id), int'(busy), 0);
        chk(int'(err) == v.exp_err, $sformatf("v%0d err_at_done", id), int'(err), v.exp_err);
      end else begin
        // Masked start with different sizes must change nothing
        start = (v.mask != 0 && cyc == 40) ? 1'b1 : 1'b0;
        if (start) out_rows = 8'd0;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk(done_cyc == v.exp_busy + 1, $sformatf("v%0d done_cycle", id), done_cyc, v.exp_busy + 1);
    chk(busy_cnt == v.exp_busy, $sformatf("v%0d busy_cycles", id), busy_cnt, v.exp_busy);
    repeat (3) @(negedge clk);
    chk(int'(err) == v.exp_err, $sformatf("v%0d err_sticky", id), int'(err), v.exp_err);
    chk(exp_q.size() == 0, $sformatf("v%0d missing_accesses", id), exp_q.size(), 0);
    exp_q.delete();
    resp_q.delete();
  endtask

  vec_t vecs[10];

  initial begin
    bit   seen;
    vec_t nv;
    //          rows cols strd nst pmax z0 all0 mask busy err
    vecs[0] = '{3,   3,   5,   5,  0,   0, 0,   1,   144, 0};
    vecs[1] = '{3,   3,   5,   5,  0,   3, 0,   0,   150, 0};
    vecs[2] = '{2,   2,   3,   2,  4,   0, 1,   0,   16,  1};
    vecs[3] = '{0,   3,   5,   5,  0,   0, 0,   0,   1,   0};
    vecs[4] = '{2,   2,   4,   1,  0,   0, 0,   0,   32,  0};
    vecs[5] = '{3,   0,   5,   2,  0,   0, 0,   0,   1,   0};
    vecs[6] = '{1,   2,   9,   8,  2,   1, 0,   0,   46,  0};
    vecs[7] = '{3,   1,   7,   2,  1,   0, 0,   0,   30,  0};
    vecs[8] = '{1,   1,   3,   1,  1,   0, 1,   0,   8,   1};
    vecs[9] = '{1,   1,   3,   1,  0,   0, 0,   0,   8,   0};

    rst = 1'b1; start = 1'b0; ctr_data_out = 32'd0;
    garble();
    repeat (3) @(negedge clk);
    chk(busy == 1'b0, "rst_busy", int'(busy), 0);
    chk(done == 1'b0, "rst_done", int'(done), 0);
    chk(err == 1'b0, "rst_err", int'(err), 0);
    chk(ctr_valid == 1'b0, "rst_valid", int'(ctr_valid), 0);
    chk(ctr_we == 1'b0, "rst_we", int'(ctr_we), 0);
    chk(ctr_addr == 10'd0, "rst_addr", int'(ctr_addr), 0);
    chk(ctr_data_in == 32'd0, "rst_data", int'(ctr_data_in), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset during a poll aborts at once with no done pulse
    nv = vecs[0];
    build(nv);
    @(negedge clk);
    apply(nv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (ctr_valid && !ctr_we) seen = 1'b1;
      else @(negedge clk);
    end
    chk(seen, "poll_reached", int'(seen), 1);
    rst = 1'b1;
    @(negedge clk);
    chk(ctr_valid == 1'b0, "rst_poll_valid", int'(ctr_valid), 0);
    chk(busy == 1'b0, "rst_poll_busy", int'(busy), 0);
    rst = 1'b0;
    exp_q.delete();
    resp_q.delete();
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || ctr_valid || busy) seen = 1'b1;
    end
    chk(!seen, "rst_poll_quiet", int'(seen), 0);

    // Reset and start together: reset wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || ctr_valid || busy) seen = 1'b1;
    end
    chk(!seen, "rst_start_quiet", int'(seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
